// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder: card side of an SPI-mode SD link.
// Receives 48-bit command frames on SD_MOSI, clocked by the host's SD_CK, and
// decodes the initialization subset (CMD0, CMD8, CMD55, ACMD41, CMD58). It
// answers with R1/R3/R7 responses on SD_MISO after NCR_BYTES of 0xFF filler.
// SD_CK and SD_MOSI are asynchronous to clk, so both are double-synchronized.
// MOSI is sampled on SD_CK rise and MISO is updated on SD_CK fall.
// Optional feature macro: SD_CRC_CHECK_EN. When it is defined, the CRC7 field of
// each frame is checked. A frame with a bad CRC gets an R1 with the CRC error
// bit set, changes no card state and does not pulse cmd_valid.
module sd_spi_card_responder #(
  parameter int          NCR_BYTES  = 1,
  parameter int          BUSY_COUNT = 2,
  parameter logic [31:0] OCR_VALUE  = 32'h00FF8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SD_CK,
  input  logic        SD_MOSI,
  output logic        SD_MISO,
  output logic        card_ready,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg
);

  localparam logic [6:0]  NCR_LAST  = 7'(NCR_BYTES * 8 - 1);
  localparam logic [15:0] BUSY_INIT = 16'(BUSY_COUNT);
  localparam logic [5:0]  LEN_R1    = 6'd8;
  localparam logic [5:0]  LEN_LONG  = 6'd40;
  localparam logic [5:0]  LAST_BIT  = 6'd47;

  typedef enum logic [2:0] {
    HUNT,
    RX,
    DECODE,
    NCR,
    TX
  } state_t;

  state_t      state;

  logic        ck_meta;
  logic        ck_sync;
  logic        ck_prev;
  logic        mosi_meta;
  logic        mosi_sync;
  logic        ck_rise;
  logic        ck_fall;

  logic [1:0]  window;
  logic [47:0] frame;
  logic [5:0]  bit_cnt;
  logic [6:0]  ncr_cnt;
  logic [5:0]  tx_cnt;
  logic [5:0]  resp_len;
  logic [39:0] resp;

  logic        idle;
  logic        app;
  logic [15:0] busy_cnt;

  logic [5:0]  dec_index;
  logic [31:0] dec_arg;
  logic        crc_ok;
  logic        frame_unused;

  logic        nxt_idle;
  logic        nxt_app;
  logic        nxt_ready;
  logic [15:0] nxt_busy;
  logic [39:0] nxt_resp;
  logic [5:0]  nxt_len;
  logic [7:0]  r1;
  logic        r1_crc;
  logic        r1_illegal;
  logic        r1_idle;
  logic        use_long;
  logic [31:0] long_tail;

  // Bring the host clock and data into the clk domain; ck_prev gives edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_meta   <= 1'b0;
      ck_sync   <= 1'b0;
      ck_prev   <= 1'b0;
      mosi_meta <= 1'b1;
      mosi_sync <= 1'b1;
    end else begin
      ck_meta   <= SD_CK;
      ck_sync   <= ck_meta;
      ck_prev   <= ck_sync;
      mosi_meta <= SD_MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  assign ck_rise = ck_sync & ~ck_prev;
  assign ck_fall = ~ck_sync & ck_prev;

  // Frame layout: [47] start, [46] transmission, [45:40] index, [39:8] arg, [7:1] CRC, [0] stop.
  assign dec_index    = frame[45:40];
  assign dec_arg      = frame[39:8];
  assign frame_unused = ^{frame[47:46], frame[7:0]};

`ifdef SD_CRC_CHECK_EN
  // CRC7 with polynomial x^7 + x^3 + 1, processed MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ 7'h09;
      end
    end
    return c;
  endfunction

  // Compare the received CRC field against the CRC of the start, index and argument bits.
  always_comb begin
    crc_ok = (crc7(frame[47:8]) == frame[7:1]);
  end
`else
  assign crc_ok = 1'b1;
`endif

  // Work out the card state after this command and the response to send back.
  always_comb begin
    nxt_idle   = idle;
    nxt_app    = app;
    nxt_busy   = busy_cnt;
    nxt_ready  = card_ready;
    r1_crc     = 1'b0;
    r1_illegal = 1'b0;
    r1_idle    = idle;
    use_long   = 1'b0;
    long_tail  = 32'h0000_0000;
    if (!crc_ok) begin
      r1_crc = 1'b1;
    end else begin
      nxt_app = 1'b0;
      case (dec_index)
        6'd0: begin
          nxt_idle  = 1'b1;
          nxt_busy  = BUSY_INIT;
          nxt_ready = 1'b0;
          r1_idle   = 1'b1;
        end
        6'd8: begin
          use_long  = 1'b1;
          long_tail = {20'h00000, dec_arg[11:0]};
        end
        6'd55: begin
          nxt_app = 1'b1;
        end
        6'd41: begin
          if (app) begin
            if (busy_cnt != 16'd0) begin
              nxt_busy = busy_cnt - 16'd1;
              r1_idle  = 1'b1;
            end else begin
              nxt_idle  = 1'b0;
              nxt_ready = 1'b1;
              r1_idle   = 1'b0;
            end
          end else begin
            r1_illegal = 1'b1;
          end
        end
        6'd58: begin
          use_long  = 1'b1;
          long_tail = {~idle, OCR_VALUE[30:0]};
        end
        default: begin
          r1_illegal = 1'b1;
        end
      endcase
    end
    r1 = {4'b0000, r1_crc, r1_illegal, 1'b0, r1_idle};
    if (use_long) begin
      nxt_resp = {r1, long_tail};
      nxt_len  = LEN_LONG;
    end else begin
      nxt_resp = {r1, 32'h0000_0000};
      nxt_len  = LEN_R1;
    end
  end

  // Main protocol FSM: hunt for a frame start, receive, decode, wait NCR, transmit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      window     <= 2'b11;
      frame      <= '0;
      bit_cnt    <= 6'd0;
      ncr_cnt    <= 7'd0;
      tx_cnt     <= 6'd0;
      resp_len   <= LEN_R1;
      resp       <= '0;
      idle       <= 1'b1;
      app        <= 1'b0;
      busy_cnt   <= BUSY_INIT;
      SD_MISO    <= 1'b1;
      card_ready <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_index  <= 6'd0;
      cmd_arg    <= 32'h0000_0000;
    end else begin
      cmd_valid <= 1'b0;
      case (state)
        HUNT: begin
          if (ck_rise) begin
            if ({window[0], mosi_sync} == 2'b01) begin
              frame   <= {46'd0, 2'b01};
              bit_cnt <= 6'd2;
              window  <= 2'b11;
              state   <= RX;
            end else begin
              window <= {window[0], mosi_sync};
            end
          end
        end
        RX: begin
          if (ck_rise) begin
            frame <= {frame[46:0], mosi_sync};
            if (bit_cnt == LAST_BIT) begin
              state <= mosi_sync ? DECODE : HUNT;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
        DECODE: begin
          if (crc_ok) begin
            cmd_valid <= 1'b1;
            cmd_index <= dec_index;
            cmd_arg   <= dec_arg;
          end
          idle       <= nxt_idle;
          app        <= nxt_app;
          busy_cnt   <= nxt_busy;
          card_ready <= nxt_ready;
          resp       <= nxt_resp;
          resp_len   <= nxt_len;
          ncr_cnt    <= 7'd0;
          state      <= NCR;
        end
        NCR: begin
          if (ck_fall) begin
            if (ncr_cnt == NCR_LAST) begin
              tx_cnt <= 6'd0;
              state  <= TX;
            end else begin
              ncr_cnt <= ncr_cnt + 7'd1;
            end
          end
        end
        TX: begin
          if (ck_fall) begin
            if (tx_cnt == resp_len) begin
              SD_MISO <= 1'b1;
              state   <= HUNT;
            end else begin
              SD_MISO <= resp[39];
              resp    <= {resp[38:0], 1'b0};
              tx_cnt  <= tx_cnt + 6'd1;
            end
          end
        end
        default: begin
          SD_MISO <= 1'b1;
          state   <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// tb_sd_spi_card_responder: host-side bench for the SPI-mode SD card responder.
// The stimulus process plays the host and pushes expected commands and responses
// into queues. Two monitor processes pop and compare whenever the card pulses
// cmd_valid or starts a response on SD_MISO.
module tb_sd_spi_card_responder;

  localparam int          NCR  = 1;
  localparam int          BUSY = 2;
  localparam logic [31:0] OCR  = 32'h00FF8000;
  localparam int          HALF = 40;
  localparam int          SCK_PERIOD = 2 * HALF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SD_CK = 1'b0;
  logic        SD_MOSI = 1'b1;
  logic        SD_MISO;
  logic        card_ready;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
  } cmd_t;

  typedef struct {
    logic [39:0] val;
    int          len;
  } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];

  int  checks = 0;
  int  fails = 0;
  int  cmd_valid_count = 0;
  int  resp_count = 0;
  time stop_time = 0;
  bit  mon_enable = 1'b1;

  sd_spi_card_responder #(
    .NCR_BYTES (NCR),
    .BUSY_COUNT(BUSY),
    .OCR_VALUE (OCR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SD_CK     (SD_CK),
    .SD_MOSI   (SD_MOSI),
    .SD_MISO   (SD_MISO),
    .card_ready(card_ready),
    .cmd_valid (cmd_valid),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg)
  );

  // System clock, well above 4x the SD_CK rate
  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Host shifts out one 48-bit frame MSB first; stop_time marks the stop-bit rise
  task automatic sendFrame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      SD_MOSI = f[i];
      #HALF;
      SD_CK = 1'b1;
      if (i == 0) stop_time = $time;
      #HALF;
      SD_CK = 1'b0;
    end
    SD_MOSI = 1'b1;
  endtask

  task automatic idleClocks(input int n);
    SD_MOSI = 1'b1;
    for (int i = 0; i < n; i++) begin
      #HALF;
      SD_CK = 1'b1;
      #HALF;
      SD_CK = 1'b0;
    end
  endtask

  // One complete host transaction with its expectations queued for the monitors
  task automatic applyStimulus(input string name, input logic [47:0] frame,
                               input int exp_valid, input logic [5:0] idx, input logic [31:0] arg,
                               input int exp_resp, input logic [39:0] rval, input int rlen,
                               input logic exp_ready);
    int   v0;
    int   r0;
    cmd_t c;
    resp_t r;
    v0 = cmd_valid_count;
    r0 = resp_count;
    if (exp_valid != 0) begin
      c.idx = idx;
      c.arg = arg;
      cmd_q.push_back(c);
    end
    if (exp_resp != 0) begin
      r.val = rval;
      r.len = rlen;
      resp_q.push_back(r);
    end
    sendFrame(frame);
    idleClocks(56);
    checkOutput({name, "_cmd_valid_count"}, 64'(cmd_valid_count - v0), 64'(exp_valid));
    checkOutput({name, "_resp_count"}, 64'(resp_count - r0), 64'(exp_resp));
    checkOutput({name, "_card_ready"}, 64'(card_ready), 64'(exp_ready));
    cmd_q.delete();
    resp_q.delete();
  endtask

  // Command monitor: every cmd_valid pulse is matched to the next queued command
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if (cmd_valid === 1'b1) begin
        cmd_valid_count++;
        if (cmd_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_cmd_valid: got index 0x%0h, expected no command", cmd_index);
        end else begin
          c = cmd_q.pop_front();
          checkOutput("cmd_index", 64'(cmd_index), 64'(c.idx));
          checkOutput("cmd_arg", 64'(cmd_arg), 64'(c.arg));
        end
      end
    end
  end

  // Response monitor: a low MISO bit starts a response; check latency, value and trailing high
  initial begin
    logic [39:0] mon_shift;
    int          mon_bits;
    bit          collecting;
    bit          tail_pending;
    resp_t       cur;
    collecting   = 1'b0;
    tail_pending = 1'b0;
    mon_shift    = '0;
    mon_bits     = 0;
    forever begin
      @(posedge SD_CK);
      if (!mon_enable) begin
        collecting   = 1'b0;
        tail_pending = 1'b0;
      end else if (tail_pending) begin
        checkOutput("miso_tail_high", 64'(SD_MISO), 64'd1);
        tail_pending = 1'b0;
        resp_count++;
      end else if (collecting) begin
        mon_shift = {mon_shift[38:0], SD_MISO};
        mon_bits++;
        if (mon_bits == cur.len) begin
          checkOutput("resp_value", 64'(mon_shift), 64'(cur.val));
          collecting   = 1'b0;
          tail_pending = 1'b1;
        end
      end else if (SD_MISO === 1'b0) begin
        if (resp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_response: got MISO 0, expected idle high");
        end else begin
          cur = resp_q.pop_front();
          checkOutput("ncr_latency", 64'(($time - stop_time) / SCK_PERIOD), 64'(NCR * 8 + 1));
          mon_shift  = {39'd0, SD_MISO};
          mon_bits   = 1;
          collecting = 1'b1;
        end
      end
    end
  end

  // Directed test sequence
  initial begin
    int v0;
    int r0;
    cmd_t c;
    rst_n   = 1'b0;
    SD_CK   = 1'b0;
    SD_MOSI = 1'b1;
    #22;
    checkOutput("reset_miso", 64'(SD_MISO), 64'd1);
    checkOutput("reset_card_ready", 64'(card_ready), 64'd0);
    checkOutput("reset_cmd_valid", 64'(cmd_valid), 64'd0);
    checkOutput("reset_cmd_index", 64'(cmd_index), 64'd0);
    checkOutput("reset_cmd_arg", 64'(cmd_arg), 64'd0);
    #20;
    rst_n = 1'b1;

    $display("[TB] idle clocking with MOSI high");
    v0 = cmd_valid_count;
    r0 = resp_count;
    idleClocks(32);
    checkOutput("idle_miso", 64'(SD_MISO), 64'd1);
    checkOutput("idle_cmd_valid_count", 64'(cmd_valid_count - v0), 64'd0);
    checkOutput("idle_resp_count", 64'(resp_count - r0), 64'd0);
    checkOutput("idle_card_ready", 64'(card_ready), 64'd0);

    $display("[TB] CMD0 / CMD8 / illegal CMD41 / bad stop bit");
    applyStimulus("cmd0", 48'h40_00000000_95, 1, 6'd0, 32'h0, 1, 40'h01, 8, 1'b0);
    applyStimulus("cmd8", 48'h48_000001AA_87, 1, 6'd8, 32'h000001AA, 1, 40'h01_000001AA, 40, 1'b0);
    applyStimulus("cmd41_noapp", 48'h69_40000000_77, 1, 6'd41, 32'h40000000, 1, 40'h05, 8, 1'b0);
    applyStimulus("stop0", 48'h40_00000000_94, 0, 6'd0, 32'h0, 0, 40'h0, 8, 1'b0);
`ifdef SD_CRC_CHECK_EN
    applyStimulus("cmd0_badcrc", 48'h40_00000000_01, 0, 6'd0, 32'h0, 1, 40'h09, 8, 1'b0);
`else
    applyStimulus("cmd0_badcrc", 48'h40_00000000_01, 1, 6'd0, 32'h0, 1, 40'h01, 8, 1'b0);
`endif

    $display("[TB] ACMD41 initialization loop");
    applyStimulus("cmd55_a", 48'h77_00000000_65, 1, 6'd55, 32'h0, 1, 40'h01, 8, 1'b0);
    applyStimulus("acmd41_a", 48'h69_40000000_77, 1, 6'd41, 32'h40000000, 1, 40'h01, 8, 1'b0);
    applyStimulus("cmd55_b", 48'h77_00000000_65, 1, 6'd55, 32'h0, 1, 40'h01, 8, 1'b0);
    applyStimulus("acmd41_b", 48'h69_40000000_77, 1, 6'd41, 32'h40000000, 1, 40'h01, 8, 1'b0);
    applyStimulus("cmd55_c", 48'h77_00000000_65, 1, 6'd55, 32'h0, 1, 40'h01, 8, 1'b0);
    applyStimulus("acmd41_c", 48'h69_40000000_77, 1, 6'd41, 32'h40000000, 1, 40'h00, 8, 1'b1);
    applyStimulus("cmd58_ready", 48'h7A_00000000_FD, 1, 6'd58, 32'h0, 1, 40'h00_80FF8000, 40, 1'b1);
    applyStimulus("cmd41_ready_noapp", 48'h69_40000000_77, 1, 6'd41, 32'h40000000, 1, 40'h04, 8, 1'b1);
    applyStimulus("cmd0_from_ready", 48'h40_00000000_95, 1, 6'd0, 32'h0, 1, 40'h01, 8, 1'b0);

    $display("[TB] reset during response transmission");
    mon_enable = 1'b0;
    c.idx = 6'd8;
    c.arg = 32'h000001AA;
    cmd_q.push_back(c);
    sendFrame(48'h48_000001AA_87);
    idleClocks(10);
    #HALF;
    checkOutput("miso_mid_tx", 64'(SD_MISO), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_miso", 64'(SD_MISO), 64'd1);
    checkOutput("abort_card_ready", 64'(card_ready), 64'd0);
    checkOutput("abort_cmd_index", 64'(cmd_index), 64'd0);
    checkOutput("abort_cmd_arg", 64'(cmd_arg), 64'd0);
    #39;
    #HALF;
    rst_n = 1'b1;
    cmd_q.delete();
    resp_q.delete();
    idleClocks(4);
    mon_enable = 1'b1;
    applyStimulus("cmd0_after_abort", 48'h40_00000000_95, 1, 6'd0, 32'h0, 1, 40'h01, 8, 1'b0);
    applyStimulus("cmd58_idle", 48'h7A_00000000_FD, 1, 6'd58, 32'h0, 1, 40'h01_00FF8000, 40, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
